// File: rtl/ppu_vram_port_pkg.sv
// ppu_vram_port_pkg
//   Shared definitions for the PPU VRAM access port: FSM state encoding,
//   CPU-visible register indices, the VRAM address width, and the address
//   increment helper.
package ppu_vram_port_pkg;

  localparam int VADDR_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  // Post-access VRAM address step; wraps naturally at 2^VADDR_W.
  function automatic logic [VADDR_W-1:0] vaddr_step(input logic [VADDR_W-1:0] addr,
                                                     input logic               step32);
    logic [VADDR_W-1:0] inc;
    if (step32) begin
      inc = 14'd32;
    end else begin
      inc = 14'd1;
    end
    vaddr_step = addr + inc;
  endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// ppu_vram_port
//   CPU-side register port of a PPU: CTRL ($2000), STATUS ($2002),
//   ADDR ($2006) and DATA ($2007). $2007 accesses are arbitrated against the
//   video fetch engine, which has priority over VRAM; the CPU is stalled via
//   lock_cpu until the access completes.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   address, in         CPU bus address and write data
//   rd, we              one-cycle CPU read / write strobes
//   out                 CPU read data (combinational)
//   lock_cpu            high while a $2007 access is in flight
//   vid_busy, vid_addr  video fetch owns VRAM / its address
//   ppu_addr            VRAM address (port address when granted, else vid_addr)
//   ppu_in              VRAM read data, valid one cycle after ppu_addr
//   ppu_out, ppu_we     VRAM write data / strobe
//   vblank_set/clr      vblank pulses from raster timing
//   ctrl, nmi           CTRL register contents, vblank & ctrl[7]
module ppu_vram_port #(
  parameter int INC_BIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  in,
  input  logic        rd,
  input  logic        we,
  output logic [7:0]  out,
  output logic        lock_cpu,
  input  logic        vid_busy,
  input  logic [13:0] vid_addr,
  output logic [13:0] ppu_addr,
  input  logic [7:0]  ppu_in,
  output logic [7:0]  ppu_out,
  output logic        ppu_we,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  output logic [7:0]  ctrl,
  output logic        nmi
);
  import ppu_vram_port_pkg::*;

  state_t              state_q,  state_d;
  logic [VADDR_W-1:0]  vaddr_q,  vaddr_d;
  logic                toggle_q, toggle_d;
  logic [7:0]          ctrl_q,   ctrl_d;
  logic                vblank_q, vblank_d;
  logic [7:0]          rdbuf_q,  rdbuf_d;
  logic [7:0]          wdata_q,  wdata_d;
  logic                op_wr_q,  op_wr_d;

  logic                reg_sel;
  logic [2:0]          reg_idx;
  logic                idle;
  logic                wr_ctrl;
  logic                rd_status;
  logic                wr_addr;
  logic                wr_data;
  logic                rd_data;
  logic                grant;
  logic                unused_addr;

  // Only the top three and bottom three address bits decode a register.
  assign unused_addr = ^address[12:3];

  // Register decode; $2006/$2007 are only accepted while no access is pending.
  always_comb begin
    reg_sel   = (address[15:13] == 3'b001);
    reg_idx   = address[2:0];
    idle      = (state_q == ST_IDLE);
    wr_ctrl   = we & reg_sel & (reg_idx == REG_CTRL);
    rd_status = rd & reg_sel & (reg_idx == REG_STATUS);
    wr_addr   = we & reg_sel & (reg_idx == REG_ADDR) & idle;
    wr_data   = we & reg_sel & (reg_idx == REG_DATA) & idle;
    // A simultaneous rd+we on $2007 is treated as a write.
    rd_data   = rd & ~we & reg_sel & (reg_idx == REG_DATA) & idle;
  end

  // CPU read mux; CTRL is write-only and reads back as zero like other holes.
  always_comb begin
    out = 8'h00;
    if (reg_sel) begin
      case (reg_idx)
        REG_STATUS: out = {vblank_q, 7'b0000000};
        REG_DATA:   out = rdbuf_q;
        default:    out = 8'h00;
      endcase
    end else begin
      out = 8'h00;
    end
  end

  // Next-state logic for registers, vblank/toggle and the access FSM.
  always_comb begin
    state_d  = state_q;
    vaddr_d  = vaddr_q;
    toggle_d = toggle_q;
    ctrl_d   = ctrl_q;
    vblank_d = vblank_q;
    rdbuf_d  = rdbuf_q;
    wdata_d  = wdata_q;
    op_wr_d  = op_wr_q;
    grant    = 1'b0;

    if (wr_ctrl) begin
      ctrl_d = in;
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_addr) begin
      if (!toggle_q) begin
        vaddr_d  = {in[5:0], vaddr_q[7:0]};
        toggle_d = 1'b1;
      end else begin
        vaddr_d  = {vaddr_q[13:8], in};
        toggle_d = 1'b0;
      end
    end else begin
      vaddr_d = vaddr_q;
    end

    // vblank_set wins over a coincident status read so the event is not lost.
    if (vblank_set) begin
      vblank_d = 1'b1;
    end else if (rd_status || vblank_clr) begin
      vblank_d = 1'b0;
    end else begin
      vblank_d = vblank_q;
    end

    if (rd_status) begin
      toggle_d = 1'b0;
    end else begin
      toggle_d = toggle_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_data) begin
          wdata_d = in;
          op_wr_d = 1'b1;
          state_d = ST_WAIT;
        end else if (rd_data) begin
          op_wr_d = 1'b0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!vid_busy) begin
          grant   = 1'b1;
          vaddr_d = vaddr_step(vaddr_q, ctrl_q[INC_BIT]);
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        if (op_wr_q) begin
          state_d = ST_IDLE;
        end else begin
          // VRAM data for the address granted last cycle is on ppu_in now;
          // it is committed to rdbuf as the FSM enters CAPTURE.
          rdbuf_d = ppu_in;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // VRAM side: the port only drives the bus in the granted WAIT cycle.
  always_comb begin
    if (grant) begin
      ppu_addr = vaddr_q;
      ppu_we   = op_wr_q;
      ppu_out  = wdata_q;
    end else begin
      ppu_addr = vid_addr;
      ppu_we   = 1'b0;
      ppu_out  = wdata_q;
    end
    lock_cpu = (state_q != ST_IDLE);
    ctrl     = ctrl_q;
    nmi      = vblank_q & ctrl_q[7];
  end

  // State registers; reset abandons any in-flight access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vaddr_q  <= 14'd0;
      toggle_q <= 1'b0;
      ctrl_q   <= 8'h00;
      vblank_q <= 1'b0;
      rdbuf_q  <= 8'h00;
      wdata_q  <= 8'h00;
      op_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vaddr_q  <= vaddr_d;
      toggle_q <= toggle_d;
      ctrl_q   <= ctrl_d;
      vblank_q <= vblank_d;
      rdbuf_q  <= rdbuf_d;
      wdata_q  <= wdata_d;
      op_wr_q  <= op_wr_d;
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
module tb_ppu_vram_port;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  cpu_in;
  logic        rd;
  logic        we;
  logic [7:0]  cpu_out;
  logic        lock_cpu;
  logic        vid_busy;
  logic [13:0] vid_addr;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_in;
  logic [7:0]  ppu_out;
  logic        ppu_we;
  logic        vblank_set;
  logic        vblank_clr;
  logic [7:0]  ctrl;
  logic        nmi;

  int errors = 0;
  int checks = 0;

  // expected VRAM writes: {addr[13:0], data[7:0]}
  logic [21:0] exp_q[$];
  logic [7:0]  vram [0:16383];

  ppu_vram_port #(.INC_BIT(2)) dut (
    .clock(clock), .reset(reset), .address(address), .in(cpu_in),
    .rd(rd), .we(we), .out(cpu_out), .lock_cpu(lock_cpu),
    .vid_busy(vid_busy), .vid_addr(vid_addr), .ppu_addr(ppu_addr),
    .ppu_in(ppu_in), .ppu_out(ppu_out), .ppu_we(ppu_we),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .ctrl(ctrl), .nmi(nmi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous-read VRAM model
  always @(posedge clock) begin
    if (ppu_we) vram[ppu_addr] <= ppu_out;
    ppu_in <= vram[ppu_addr];
  end

  // scoreboard: every VRAM write strobe must match the next expected write
  always @(negedge clock) begin
    if (ppu_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vram_write unexpected: addr=%h data=%h, required none", ppu_addr, ppu_out);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({ppu_addr, ppu_out} !== e) begin
          errors++;
          $display("FAIL vram_write: addr=%h data=%h, required addr=%h data=%h",
                   ppu_addr, ppu_out, e[21:8], e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] r, input logic [7:0] d);
    address = {13'h0400, r};
    cpu_in  = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] r, output logic [7:0] d);
    address = {13'h0400, r};
    rd      = 1'b1;
    #1;
    d       = cpu_out;
    step();
    rd      = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!lock_cpu) begin
        done = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle timeout: lock_cpu=%b, required 0 within 20 cycles", lock_cpu);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    vid_addr = 14'h1234;
    #1;
    checks++; if (lock_cpu !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b, required 0", lock_cpu); end
    checks++; if (ppu_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", ppu_we); end
    checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL reset_nmi: got %b, required 0", nmi); end
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h, required 00", ctrl); end
    checks++; if (ppu_addr !== 14'h1234) begin errors++; $display("FAIL reset_ppu_addr: got %h, required 1234", ppu_addr); end
    address = 16'h2002;
    #1;
    d = cpu_out;
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h, required 00", d); end
  endtask

  task automatic test_write_basic();
    int cnt;
    cpu_wr(3'd6, 8'h21);
    cpu_wr(3'd6, 8'h08);
    exp_q.push_back({14'h2108, 8'h5A});
    cpu_wr(3'd7, 8'h5A);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!lock_cpu) break;
      cnt++;
      step();
    end
    checks++; if (cnt != 2) begin errors++; $display("FAIL lock_len: got %0d cycles, required 2", cnt); end
    // vaddr must now be $2109
    exp_q.push_back({14'h2109, 8'hA5});
    cpu_wr(3'd7, 8'hA5);
    wait_idle();
  endtask

  task automatic test_inc32();
    cpu_wr(3'd0, 8'h04);
    checks++; if (ctrl !== 8'h04) begin errors++; $display("FAIL ctrl_out: got %h, required 04", ctrl); end
    cpu_wr(3'd6, 8'h20);
    cpu_wr(3'd6, 8'h00);
    exp_q.push_back({14'h2000, 8'h11});
    cpu_wr(3'd7, 8'h11);
    wait_idle();
    exp_q.push_back({14'h2020, 8'h22});
    cpu_wr(3'd7, 8'h22);
    wait_idle();
  endtask

  task automatic test_vid_busy();
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd6, 8'h10);
    cpu_wr(3'd6, 8'h00);
    vid_busy = 1'b1;
    vid_addr = 14'h0ABC;
    exp_q.push_back({14'h1000, 8'h33});
    cpu_wr(3'd7, 8'h33);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ppu_we !== 1'b0 || ppu_addr !== 14'h0ABC || lock_cpu !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold[%0d]: we=%b addr=%h lock=%b, required we=0 addr=0abc lock=1",
                 i, ppu_we, ppu_addr, lock_cpu);
      end
      // a $2006 write while locked must be ignored
      if (i == 2) cpu_wr(3'd6, 8'h3F);
      else step();
    end
    vid_busy = 1'b0;
    #1;
    checks++;
    if (ppu_we !== 1'b1 || ppu_addr !== 14'h1000) begin
      errors++;
      $display("FAIL busy_grant: we=%b addr=%h, required we=1 addr=1000", ppu_we, ppu_addr);
    end
    wait_idle();
    exp_q.push_back({14'h1001, 8'h44});
    cpu_wr(3'd7, 8'h44);
    wait_idle();
  endtask

  task automatic test_read();
    logic [7:0] d;
    vram[14'h0010] = 8'h77;
    cpu_wr(3'd6, 8'h00);
    cpu_wr(3'd6, 8'h10);
    cpu_rd(3'd7, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL read_first: got %h, required 00", d); end
    wait_idle();
    cpu_rd(3'd7, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL read_second: got %h, required 77", d); end
    wait_idle();
  endtask

  task automatic test_vblank();
    logic [7:0] d;
    cpu_wr(3'd0, 8'h80);
    vblank_set = 1'b1;
    step();
    vblank_set = 1'b0;
    checks++; if (nmi !== 1'b1) begin errors++; $display("FAIL nmi_set: got %b, required 1", nmi); end
    address = 16'h2001;
    #1;
    checks++; if (cpu_out !== 8'h00) begin errors++; $display("FAIL unimpl_read: got %h, required 00", cpu_out); end
    address = 16'h4002;
    #1;
    checks++; if (cpu_out !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h, required 00", cpu_out); end
    cpu_wr(3'd6, 8'h3F);  // leaves toggle set
    cpu_rd(3'd2, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL status_read: got %h, required 80", d); end
    checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_clear: got %b, required 0", nmi); end
    cpu_wr(3'd6, 8'h21);
    cpu_wr(3'd6, 8'h08);
    exp_q.push_back({14'h2108, 8'h66});
    cpu_wr(3'd7, 8'h66);
    wait_idle();
    // status read coinciding with vblank_set: reads 0, vblank stays set
    vblank_set = 1'b1;
    cpu_rd(3'd2, d);
    vblank_set = 1'b0;
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL status_race_read: got %h, required 00", d); end
    checks++; if (nmi !== 1'b1) begin errors++; $display("FAIL status_race_nmi: got %b, required 1", nmi); end
    vblank_clr = 1'b1;
    step();
    vblank_clr = 1'b0;
    checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL vblank_clr: got %b, required 0", nmi); end
  endtask

  task automatic test_reset_mid();
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd6, 8'h3F);
    cpu_wr(3'd6, 8'hFF);
    vid_busy = 1'b1;
    cpu_wr(3'd7, 8'h99);  // no write expected: abandoned by reset
    reset = 1'b1;
    #1;
    checks++;
    if (lock_cpu !== 1'b0 || ppu_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: lock=%b we=%b, required 0 0", lock_cpu, ppu_we);
    end
    vid_busy = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (lock_cpu !== 1'b0 || ppu_addr !== vid_addr) begin
      errors++;
      $display("FAIL reset_mid_after: lock=%b addr=%h, required lock=0 addr=%h", lock_cpu, ppu_addr, vid_addr);
    end
    cpu_wr(3'd6, 8'h3F);
    cpu_wr(3'd6, 8'hFF);
    exp_q.push_back({14'h3FFF, 8'hAA});
    cpu_wr(3'd7, 8'hAA);
    wait_idle();
    exp_q.push_back({14'h0000, 8'hBB});
    cpu_wr(3'd7, 8'hBB);
    wait_idle();
    cpu_wr(3'd0, 8'h04);
    cpu_wr(3'd6, 8'h3F);
    cpu_wr(3'd6, 8'hE0);
    exp_q.push_back({14'h3FE0, 8'hCC});
    cpu_wr(3'd7, 8'hCC);
    wait_idle();
    exp_q.push_back({14'h0000, 8'hDD});
    cpu_wr(3'd7, 8'hDD);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd6, 8'h05);
    cpu_wr(3'd6, 8'h00);
    exp_q.push_back({14'h0500, 8'h12});
    cpu_wr(3'd7, 8'h12);
    cpu_wr(3'd7, 8'h34);  // lands while locked: ignored
    wait_idle();
    exp_q.push_back({14'h0501, 8'h56});
    cpu_wr(3'd7, 8'h56);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    reset      = 1'b1;
    address    = 16'h0000;
    cpu_in     = 8'h00;
    rd         = 1'b0;
    we         = 1'b0;
    vid_busy   = 1'b0;
    vid_addr   = 14'h0000;
    vblank_set = 1'b0;
    vblank_clr = 1'b0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_write_basic();
    test_inc32();
    test_vid_busy();
    test_read();
    test_vblank();
    test_reset_mid();
    test_back_to_back();
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_vram_port.md
PPU_VRAM_PORT -- requirements
Module: ppu_vram_port

Interface
REQ-001 Parameter INC_BIT, default 2: bit of CTRL ($2000) selecting the VRAM address increment, 0 = +1, 1 = +32.
REQ-002 clock  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 address  input  16  CPU bus address; registers selected when address[15:13]=3'b001, register = address[2:0].
REQ-005 in  input  8  CPU write data.
REQ-006 rd, we  input  1 each  one-cycle CPU read/write strobes; each asserted cycle is one access.
REQ-007 out  output  8  CPU read data, combinational from address and current state.
REQ-008 lock_cpu  output  1  high while a $2007 access is pending; CPU stalls.
REQ-009 vid_busy  input  1  video fetch owns VRAM this cycle.
REQ-010 vid_addr  input  14  video fetch address.
REQ-011 ppu_addr  output  14  VRAM address: vaddr when granted, else vid_addr.
REQ-012 ppu_in  input  8  VRAM read data, valid one cycle after ppu_addr.
REQ-013 ppu_out  output  8  VRAM write data.
REQ-014 ppu_we  output  1  VRAM write strobe.
REQ-015 vblank_set, vblank_clr  input  1 each  one-cycle pulses from raster timing.
REQ-016 ctrl  output  8  CTRL register contents; nmi  output  1  = vblank & ctrl[7].

Function
REQ-017 Write $2000 loads ctrl <= in; write $2006 with toggle=0 loads vaddr[13:8] <= in[5:0], toggle <= 1; with toggle=1 loads vaddr[7:0] <= in, toggle <= 0.
REQ-018 Read $2002 returns {vblank, 7'b0} and, same edge, clears vblank and toggle; vblank_set sets vblank, vblank_clr clears it; a $2002 read coinciding with vblank_set reads 0 and leaves vblank set.
REQ-019 FSM states IDLE, WAIT, ISSUE, CAPTURE.
REQ-020 IDLE: $2007 write latches wdata <= in, op <= write, goes WAIT; $2007 read returns rdbuf on out, op <= read, goes WAIT.
REQ-021 WAIT: if vid_busy=0, grant asserted this cycle (ppu_addr = vaddr; ppu_we = 1 for write, ppu_out = wdata) and move to ISSUE; else remain WAIT.
REQ-022 ISSUE: write returns to IDLE; read moves to CAPTURE; vaddr <= (vaddr + inc) mod 2^14 on leaving WAIT, inc = ctrl[INC_BIT] ? 32 : 1.
REQ-023 CAPTURE: rdbuf <= ppu_in, return to IDLE; vid_busy is ignored here.
REQ-024 lock_cpu = (state != IDLE); worst-case grant latency one cycle after vid_busy falls.
REQ-025 Register accesses to $2006/$2007 while lock_cpu=1 are ignored; $2000/$2002 accesses are always serviced.
REQ-026 vaddr wraps 14 bits: $3FFF + 1 -> $0000, $3FE0 + 32 -> $0000.
REQ-027 Reads of unimplemented registers return 8'h00.

Reset
REQ-028 Asynchronous reset forces state=IDLE, vaddr=0, toggle=0, ctrl=0, vblank=0, rdbuf=0, wdata=0; outputs lock_cpu=0, ppu_we=0, nmi=0, ppu_addr=vid_addr.
REQ-029 Reset during WAIT/ISSUE/CAPTURE abandons the access; no VRAM write after reset asserts.

Structure
REQ-030 Shared package holds FSM state encoding, register indices (CTRL=0, STATUS=2, ADDR=6, DATA=7) and VADDR_W=14.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 Write $2006=$21, $2006=$08, $2007=$5A, vid_busy=0 -> ppu_we at $2108 data $5A, vaddr=$2109, lock_cpu high exactly 2 cycles.
REQ-033 ctrl=$04, vaddr=$2000, two $2007 writes -> VRAM writes at $2000 and $2020.
REQ-034 vid_busy held 5 cycles during pending write -> ppu_we only after vid_busy falls; ppu_addr=vid_addr while busy.
REQ-035 VRAM[$0010]=$77, vaddr=$0010, two $2007 reads -> first returns old rdbuf $00, second returns $77.
REQ-036 vblank_set, ctrl=$80 -> nmi=1; $2002 read returns $80, then nmi=0 and toggle=0 (next $2006 write hits high byte).
REQ-037 Reset asserted in WAIT of a write, vaddr=$3FFF wrap case -> no ppu_we, state IDLE; separately $3FFF write leaves vaddr=$0000.
